// File: rtl/gcd_pkg.sv
// Shared defaults and FSM encoding for the gcd job master and its job FIFO.
package gcd_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int TAG_W_DEF       = 4;
    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int TIMEOUT_CYC_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } gcd_state_t;

endpackage

// File: rtl/gcd_job_fifo.sv
// Synchronous FIFO of packed {tag, a, b, c} jobs; the head entry is presented on rdata while not empty.
module gcd_job_fifo
    import gcd_pkg::*;
#(
    parameter int WIDTH = TAG_W_DEF + 3 * DATA_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_job_master.sv
// Initiator for a gcd engine: queues operand jobs, issues one at a time with a start pulse,
// and returns result, tag and timeout flag on a valid/ready port.
//   state | meaning
//   IDLE  | no job in flight, waiting for the FIFO to hold a job
//   ISSUE | gcd_start high for this single cycle, timeout counter loaded
//   WAIT  | operands held, waiting for gcd_valid or timeout
//   RESP  | result held on res_* until res_ready
module gcd_job_master
    import gcd_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TAG_W       = TAG_W_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_a,
    input  logic [DATA_W-1:0] job_b,
    input  logic [DATA_W-1:0] job_c,
    input  logic [TAG_W-1:0]  job_tag,
    output logic              gcd_start,
    output logic [DATA_W-1:0] gcd_a,
    output logic [DATA_W-1:0] gcd_b,
    output logic [DATA_W-1:0] gcd_c,
    input  logic [DATA_W-1:0] gcd_d,
    input  logic              gcd_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_d,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_timeout,
    output logic              busy,
    output logic              stray_valid
);

    localparam int ENTRY_W = TAG_W + 3 * DATA_W;
    localparam int TMO_W   = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    gcd_state_t         state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TAG_W-1:0]   job_tag_q;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [DATA_W-1:0]  head_c;
    logic [TAG_W-1:0]   head_tag;

    assign fifo_wdata = {job_tag, job_a, job_b, job_c};
    assign {head_tag, head_a, head_b, head_c} = fifo_rdata;
    assign job_ready  = !fifo_full;
    assign fifo_push  = job_valid && !fifo_full;
    assign busy       = (state != ST_IDLE) || !fifo_empty;

    // A job leaves the FIFO from IDLE, or on the result handshake for zero-bubble turnaround.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE) begin
                fifo_pop = 1'b1;
            end else if (state == ST_RESP && res_ready) begin
                fifo_pop = 1'b1;
            end
        end
    end

    gcd_job_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            gcd_start   <= 1'b0;
            gcd_a       <= '0;
            gcd_b       <= '0;
            gcd_c       <= '0;
            job_tag_q   <= '0;
            tmo_cnt     <= '0;
            res_valid   <= 1'b0;
            res_d       <= '0;
            res_tag     <= '0;
            res_timeout <= 1'b0;
            stray_valid <= 1'b0;
        end else begin
            gcd_start <= 1'b0;
            if (gcd_valid && (state == ST_IDLE || state == ST_RESP)) begin
                stray_valid <= 1'b1;
            end
            if (fifo_pop) begin
                gcd_a     <= head_a;
                gcd_b     <= head_b;
                gcd_c     <= head_c;
                job_tag_q <= head_tag;
            end
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        gcd_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    // Engine completion takes priority over a timeout in the same cycle.
                    if (gcd_valid) begin
                        res_d       <= gcd_d;
                        res_tag     <= job_tag_q;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else if (state == ST_WAIT && tmo_cnt == '0) begin
                        res_d       <= '0;
                        res_tag     <= job_tag_q;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                    tmo_cnt <= (state == ST_ISSUE) ? TMO_LOAD : tmo_cnt - 1'b1;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (!fifo_empty) begin
                            gcd_start <= 1'b1;
                            state     <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
